// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned HAZ_DEPTH_DEF = 3;
    localparam int unsigned NUM_REGS      = 32;

    typedef logic [4:0] reg_addr_t;
    // Busy counter wide enough for the default depth.
    typedef logic [$clog2(HAZ_DEPTH_DEF + 1) - 1:0] sb_cnt_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker: a countdown per register, plus the two
// source-operand hazard lookups for the instruction in ID.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned HAZ_DEPTH = HAZ_DEPTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic       set_en_i,
    input  logic [4:0] set_addr_i,
    output logic       haz_o
);

    localparam int unsigned CntW = (HAZ_DEPTH < 1) ? 1 : $clog2(HAZ_DEPTH + 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(HAZ_DEPTH);

    logic [CntW-1:0] busy_q [NUM_REGS];
    logic [CntW-1:0] busy_d [NUM_REGS];
    logic            rs1_hit;
    logic            rs2_hit;

    // A new issue to the same register wins over its own decrement.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = (busy_q[i] != '0) ? busy_q[i] - CntW'(1) : '0;
            if (set_en_i && (set_addr_i == reg_addr_t'(i))) begin
                busy_d[i] = LoadVal;
            end
        end
        busy_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_q[i] <= busy_d[i];
            end
        end
    end

    assign rs1_hit = rs1_used_i && (rs1_addr_i != '0) && (busy_q[rs1_addr_i] != '0);
    assign rs2_hit = rs2_used_i && (rs2_addr_i != '0) && (busy_q[rs2_addr_i] != '0);
    assign haz_o   = rs1_hit || rs2_hit;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage non-forwarding pipeline: drives
// PC hold, IF/ID hold/clear and the ID/EX bubble, and counts stalls/flushes.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned HAZ_DEPTH = HAZ_DEPTH_DEF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_addr_ID,
    input  logic             rd_wren_ID,
    input  logic             br_taken_EX,
    output logic             pc_enable_no,
    output logic             fd_enable_no,
    output logic             fd_clear_o,
    output logic             de_clear_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic             haz;
    logic             flush;
    logic             stall;
    logic             issue;
    logic             set_en;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    hazard_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rs1_addr_i (rs1_addr_ID),
        .rs2_addr_i (rs2_addr_ID),
        .rs1_used_i (rs1_used_ID),
        .rs2_used_i (rs2_used_ID),
        .set_en_i   (set_en),
        .set_addr_i (rd_addr_ID),
        .haz_o      (haz)
    );

    // A redirect squashes the ID instruction, so it must not wait or claim rd.
    assign flush  = br_taken_EX;
    assign stall  = haz && !flush;
    assign issue  = !stall && !flush;
    assign set_en = issue && rd_wren_ID && (rd_addr_ID != '0);

    always_comb begin
        pc_enable_no = 1'b0;
        fd_enable_no = 1'b0;
        fd_clear_o   = 1'b0;
        de_clear_o   = 1'b0;
        if (!rst_ni || flush) begin
            fd_clear_o = 1'b1;
            de_clear_o = 1'b1;
        end else if (stall) begin
            pc_enable_no = 1'b1;
            fd_enable_no = 1'b1;
            de_clear_o   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: control outputs go through an expectation
// queue; counters and scoreboard entries are checked at fixed points.
module tb_hazard_unit;

    localparam int unsigned HazDepth = 3;
    localparam int unsigned CntW     = 4;

    localparam logic [3:0] CtlIssue = 4'b0000;  // {pc_en_n, fd_en_n, fd_clr, de_clr}
    localparam logic [3:0] CtlStall = 4'b1101;
    localparam logic [3:0] CtlFlush = 4'b0011;

    logic            clk_i;
    logic            rst_ni;
    logic [4:0]      rs1_addr_ID;
    logic [4:0]      rs2_addr_ID;
    logic            rs1_used_ID;
    logic            rs2_used_ID;
    logic [4:0]      rd_addr_ID;
    logic            rd_wren_ID;
    logic            br_taken_EX;
    logic            pc_enable_no;
    logic            fd_enable_no;
    logic            fd_clear_o;
    logic            de_clear_o;
    logic [CntW-1:0] stall_cnt_o;
    logic [CntW-1:0] flush_cnt_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q [$];
    string      tag_q [$];

    hazard_unit #(
        .HAZ_DEPTH (HazDepth),
        .CNT_W     (CntW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rs1_addr_ID  (rs1_addr_ID),
        .rs2_addr_ID  (rs2_addr_ID),
        .rs1_used_ID  (rs1_used_ID),
        .rs2_used_ID  (rs2_used_ID),
        .rd_addr_ID   (rd_addr_ID),
        .rd_wren_ID   (rd_wren_ID),
        .br_taken_EX  (br_taken_EX),
        .pc_enable_no (pc_enable_no),
        .fd_enable_no (fd_enable_no),
        .fd_clear_o   (fd_clear_o),
        .de_clear_o   (de_clear_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr,
                          input logic br);
        rs1_addr_ID = rs1;
        rs1_used_ID = u1;
        rs2_addr_ID = rs2;
        rs2_used_ID = u2;
        rd_addr_ID  = rd;
        rd_wren_ID  = wr;
        br_taken_EX = br;
    endtask

    // One cycle: queue the expected controls, compare mid-cycle, advance past the edge.
    task automatic step(input string tag, input logic [3:0] exp);
        logic [3:0] e;
        string      t;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk_i);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 32'({pc_enable_no, fd_enable_no, fd_clear_o, de_clear_o}), 32'(e));
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_busy_empty(input string tag);
        logic any;
        any = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (dut.u_sb.busy_q[i] != '0) any = 1'b1;
        end
        chk(tag, 32'(any), 32'(0));
    endtask

    initial begin
        rst_ni = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("reset_ctl0", CtlFlush);
        step("reset_ctl1", CtlFlush);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 32'(0));
        chk("reset_flush_cnt", 32'(flush_cnt_o), 32'(0));
        chk_busy_empty("reset_busy");
        rst_ni = 1'b1;

        // Back-to-back dependency: exactly HazDepth stall cycles.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step("b2b_prod", CtlIssue);
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("b2b_stall1", CtlStall);
        step("b2b_stall2", CtlStall);
        step("b2b_stall3", CtlStall);
        step("b2b_issue", CtlIssue);
        chk("b2b_stall_cnt", 32'(stall_cnt_o), 32'(3));

        // Distance 2 on rs2: two stalls.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        step("d2_prod", CtlIssue);
        set_id(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        step("d2_indep", CtlIssue);
        set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        step("d2_stall1", CtlStall);
        step("d2_stall2", CtlStall);
        step("d2_issue", CtlIssue);
        chk("d2_stall_cnt", 32'(stall_cnt_o), 32'(5));

        // Busy source with used bits clear does not stall.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step("unused_prod", CtlIssue);
        set_id(5'd8, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        step("unused_cons", CtlIssue);

        // rs1 == rs2: one hazard, HazDepth stalls.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        step("same_src_prod", CtlIssue);
        set_id(5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        step("same_src_stall1", CtlStall);
        step("same_src_stall2", CtlStall);
        step("same_src_stall3", CtlStall);
        step("same_src_issue", CtlIssue);
        chk("same_src_stall_cnt", 32'(stall_cnt_o), 32'(8));

        // x0 is never tracked.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("x0_prod", CtlIssue);
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        step("x0_cons", CtlIssue);
        chk_busy_empty("x0_busy_empty");

        // Flush overrides a live hazard; the squashed rd=9 is not claimed.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step("fl_prod", CtlIssue);
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        step("fl_flush", CtlFlush);
        chk("fl_busy9", 32'(dut.u_sb.busy_q[9]), 32'(0));
        chk("fl_busy3_counts", 32'(dut.u_sb.busy_q[3]), 32'(2));
        chk("fl_flush_cnt", 32'(flush_cnt_o), 32'(1));
        chk("fl_stall_cnt", 32'(stall_cnt_o), 32'(8));
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        step("fl_stall1", CtlStall);
        step("fl_stall2", CtlStall);
        step("fl_issue", CtlIssue);
        chk("fl_stall_cnt2", 32'(stall_cnt_o), 32'(10));

        // Reissue of the same rd reloads the countdown.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        step("re_prod1", CtlIssue);
        step("re_prod2", CtlIssue);
        chk("re_busy4_3", 32'(dut.u_sb.busy_q[4]), 32'(3));
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("re_idle1", CtlIssue);
        chk("re_busy4_2", 32'(dut.u_sb.busy_q[4]), 32'(2));
        step("re_idle2", CtlIssue);
        chk("re_busy4_1", 32'(dut.u_sb.busy_q[4]), 32'(1));
        step("re_idle3", CtlIssue);
        chk("re_busy4_0", 32'(dut.u_sb.busy_q[4]), 32'(0));

        // Reset during a stall with busy[5]=2.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step("rs_prod", CtlIssue);
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("rs_stall", CtlStall);
        chk("rs_busy5", 32'(dut.u_sb.busy_q[5]), 32'(2));
        rst_ni = 1'b0;
        step("rs_forced", CtlFlush);
        rst_ni = 1'b1;
        chk_busy_empty("rs_busy_empty");
        chk("rs_stall_cnt", 32'(stall_cnt_o), 32'(0));
        chk("rs_flush_cnt", 32'(flush_cnt_o), 32'(0));
        step("rs_cons_issue", CtlIssue);

        // Counter saturation at all-ones.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step("sat_flush", CtlFlush);
        end
        chk("sat_flush_cnt", 32'(flush_cnt_o), 32'(15));
        chk("sat_stall_cnt", 32'(stall_cnt_o), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall/flush controller for the five-stage (IF, ID, EX, MEM, WB) non-forwarding pipeline. It drives the control side of the pipeline registers: the `clear_i`/`enable_ni` pair of the IF/ID register, the PC hold, and the bubble insert into ID/EX. A per-register scoreboard tracks in-flight writes. The unit stalls any ID-stage instruction whose source operands are not yet written back, and it flushes wrong-path instructions on a redirect resolved in EX.

## Interface
Parameters:
- `HAZ_DEPTH`, default 3: cycles from issue into EX until the register-file write is visible to an ID-stage read. Use 3 for a write-at-end-of-WB regfile, 2 for a write-first regfile.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `rs1_addr_ID`, in, 5: rs1 of the instruction in ID.
- `rs2_addr_ID`, in, 5: rs2 of the instruction in ID.
- `rs1_used_ID`, in, 1: instruction reads rs1.
- `rs2_used_ID`, in, 1: instruction reads rs2.
- `rd_addr_ID`, in, 5: destination of the instruction in ID.
- `rd_wren_ID`, in, 1: instruction writes rd.
- `br_taken_EX`, in, 1: branch or jump in EX redirects the PC this cycle.
- `pc_enable_no`, out, 1: 1 holds the PC.
- `fd_enable_no`, out, 1: 1 holds IF/ID; drives `enable_ni`.
- `fd_clear_o`, out, 1: 1 zeroes IF/ID; drives `clear_i`.
- `de_clear_o`, out, 1: 1 loads a bubble into ID/EX.
- `stall_cnt_o`, out, CNT_W: count of stall cycles, saturating.
- `flush_cnt_o`, out, CNT_W: count of flush cycles, saturating.

## Operation
Scoreboard:
- State is `busy[1..31]`, each `$clog2(HAZ_DEPTH+1)` bits wide. Entry x0 is constant 0 and is never written.
- `haz = (rs1_used_ID & rs1_addr_ID!=0 & busy[rs1_addr_ID]!=0) | (same for rs2)`.

Control outputs (combinational, same cycle):
- `flush = br_taken_EX`.
- `stall = haz & ~flush`; a flush overrides a stall.
- `issue = ~stall & ~flush`.
- When `flush`: `fd_clear_o=1`, `de_clear_o=1`, `pc_enable_no=0`, `fd_enable_no=0`.
- When `stall`: `pc_enable_no=1`, `fd_enable_no=1`, `de_clear_o=1`, `fd_clear_o=0`.
- Otherwise all four outputs are 0.

Scoreboard update per edge:
- Every nonzero entry decrements by 1.
- If `issue & rd_wren_ID & rd_addr_ID!=0`, set `busy[rd_addr_ID]=HAZ_DEPTH`. The set wins over the decrement of the same entry.
- A flushed or stalled ID instruction never sets an entry.
- Entries owned by older instructions (already in EX/MEM/WB) keep counting down through a flush. Those instructions are older than the branch and still commit.

Counters:
- `stall_cnt_o` increments on every cycle where `stall=1`.
- `flush_cnt_o` increments on every cycle where `flush=1`.
- Both saturate at all-ones.

## Timing
Reset:
- `rst_ni=0` at an edge clears all `busy` entries and both counters.
- While `rst_ni=0`, outputs are forced to `fd_clear_o=1`, `de_clear_o=1`, `pc_enable_no=0`, `fd_enable_no=0`.
- Reset asserted mid-stall drops the stall on the same cycle; the scoreboard is empty after the edge.

Latency and throughput:
- Zero cycles from inputs to control outputs.
- A dependent instruction in ID stalls for exactly `HAZ_DEPTH` cycles when its producer issues in the immediately preceding cycle.
- Producer at distance k (k-1 independent instructions between them) causes `max(0, HAZ_DEPTH-k+1)` stall cycles.

Boundary cases:
- Back-to-back writes to the same rd: the second issue reloads the counter to `HAZ_DEPTH`.
- rs1==rs2: handled as a single hazard.
- Writes to x0: never tracked.
- A source with its `used` bit clear never stalls.
- Flush on the same cycle as a hazard: flush only, no stall count, no set.

## Structure
- `hazard_pkg` holds `HAZ_DEPTH_DEF`, `reg_addr_t` (logic[4:0]) and `sb_cnt_t`.
- One sub-module, `hazard_scoreboard`, owns the busy array, decrement/set logic and the two hazard lookups.
- `hazard_unit` holds the priority logic, reset forcing and the performance counters.

## Test plan
- **Back-to-back dependency:** with `HAZ_DEPTH=3`, issue `rd=5 wren=1`, then next ID has `rs1=5 used=1`.
  - `stall=1` for exactly 3 cycles, then `issue`.
  - `stall_cnt_o=3`.
- **Distance 2, plus unused source:** producer `rd=7`, one independent instruction, then consumer `rs2=7`.
  - Exactly 2 stall cycles.
  - A consumer with `rs2_used=0` gets 0 stalls.
- **x0 never tracked:** issue `rd=0 wren=1`, then a consumer `rs1=0`.
  - No stall.
  - `busy` all zero.
- **Flush overrides stall:** hold a hazard on `rs1=3` and assert `br_taken_EX` in the same cycle.
  - `fd_clear_o=1`, `de_clear_o=1`, `pc_enable_no=0`.
  - The ID instruction's `rd=9` is not set.
  - `flush_cnt_o=1`, `stall_cnt_o` unchanged.
- **Same rd reissued:** issue `rd=4`; 1 cycle later issue `rd=4` again.
  - `busy[4]` reads 3 after the second edge, then 2, 1, 0.
- **Reset mid-stall:** pull `rst_ni=0` for one edge during a stall with `busy[5]=2`.
  - Outputs forced to the reset values while low.
  - After release, the scoreboard is empty and both counters read 0.
